bcd_accum_n: RTL and testbench

Parametrised digit-serial BCD accumulator; successor to the fixed 4-digit, add-only accumulator in the matrix-multiplier datapath. Accepts an IN_DIGITS-digit BCD operand through a valid/ready handshake and adds it to, or subtracts it from, an ACC_DIGITS-digit running total, processing one digit per clock. It adds selectable wrap/saturate overflow handling, sticky overflow and invalid-digit flags, and a completion pulse for the matrix-multiplier controller.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_addsub.sv | 30 +++
 rtl/bcd_accum_n.sv | 178 +++++++++++++++++
 tb/tb_bcd_accum_n.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and nibble validity helper for the
// digit-serial BCD accumulator.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic nibble_invalid(input logic [BCD_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD adder/subtractor; subtraction adds the
// nines' complement of b, so cout=1 means "no borrow".
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [BCD_W-1:0] s,
  output logic             cout
);

  logic [BCD_W-1:0] w_b;
  logic [BCD_W:0]   w_sum;

  // Binary sum of the digit pair with decimal correction above 9.
  always_comb begin
    w_b   = sub ? (4'd9 - b) : b;
    w_sum = {1'b0, a} + {1'b0, w_b} + {4'd0, cin};
    if (w_sum > 5'd9) begin
      s    = 4'(w_sum - 5'd10);
      cout = 1'b1;
    end else begin
      s    = w_sum[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_accum_n.sv
// Digit-serial BCD accumulator: adds/subtracts an IN_DIGITS operand to an
// ACC_DIGITS running total one digit per clock, with wrap/saturate handling.
module bcd_accum_n
  import bcd_pkg::*;
#(
  parameter int ACC_DIGITS = 4,
  parameter int IN_DIGITS  = 2,
  parameter int SATURATE   = 0
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [BCD_W*IN_DIGITS-1:0]    IN_DATA,
  input  logic                          SUB,
  input  logic                          FLAG_CLR,
  output logic [BCD_W*ACC_DIGITS-1:0]   Q,
  output logic                          DONE,
  output logic                          OVF,
  output logic                          ERR
);

  localparam int                QW       = BCD_W * ACC_DIGITS;
  localparam int                IDX_W    = $clog2(ACC_DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ACC_DIGITS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [QW-1:0]     r_work;
  logic [QW-1:0]     r_op;
  logic [QW-1:0]     r_q;
  logic              r_sub;
  logic              r_carry;
  logic              r_bad;
  logic              r_done;
  logic              r_ovf;
  logic              r_err;

  logic              w_accept;
  logic              w_bad_in;
  logic              w_ovf_set;
  logic [QW-1:0]     w_op_ext;
  logic [QW-1:0]     w_fin;
  logic [BCD_W-1:0]  w_a;
  logic [BCD_W-1:0]  w_b;
  logic [BCD_W-1:0]  w_s;
  logic              w_cout;

  // Operand zero-extension, digit validity and current-digit selection.
  always_comb begin
    w_accept = IN_VALID && (r_state == IDLE);
    w_op_ext = '0;
    w_op_ext[BCD_W*IN_DIGITS-1:0] = IN_DATA;
    w_bad_in = 1'b0;
    for (int i = 0; i < IN_DIGITS; i++) begin
      w_bad_in = w_bad_in | nibble_invalid(IN_DATA[i*BCD_W +: BCD_W]);
    end
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      w_a = (r_idx == IDX_W'(i)) ? r_work[i*BCD_W +: BCD_W] : w_a;
      w_b = (r_idx == IDX_W'(i)) ? r_op[i*BCD_W +: BCD_W]   : w_b;
    end
  end

  bcd_digit_addsub u_digit (
    .a    (w_a),
    .b    (w_b),
    .sub  (r_sub),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Final carry resolution: an add carrying out or a subtract borrowing out overflows.
  always_comb begin
    w_ovf_set = (r_state == FIN) && !r_bad && (r_carry != r_sub);
    if (w_ovf_set && (SATURATE != 0)) begin
      w_fin = r_sub ? {QW{1'b0}} : {ACC_DIGITS{4'd9}};
    end else begin
      w_fin = r_work;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_bad_in ? FIN : RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_next = FIN;
        end else begin
          w_next = RUN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: operand capture, digit-serial update of the working copy, commit.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_idx   <= '0;
      r_work  <= '0;
      r_op    <= '0;
      r_q     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_bad   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_op_ext;
            r_sub   <= SUB;
            r_carry <= SUB;
            r_idx   <= '0;
            r_work  <= r_q;
            r_bad   <= w_bad_in;
          end
        end
        RUN: begin
          for (int i = 0; i < ACC_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_work[i*BCD_W +: BCD_W] <= w_s;
            end
          end
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
        end
        FIN: begin
          r_q <= w_fin;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  // Sticky flags; a set condition at the same edge overrides FLAG_CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~FLAG_CLR);
      r_err <= (w_accept & w_bad_in) | (r_err & ~FLAG_CLR);
    end
  end

  assign IN_READY = (r_state == IDLE);
  assign Q        = r_q;
  assign DONE     = r_done;
  assign OVF      = r_ovf;
  assign ERR      = r_err;

endmodule

// File: tb/tb_bcd_accum_n.sv
// Scoreboard bench for bcd_accum_n: a decimal-arithmetic reference model
// pushes expected results, per-DUT monitors pop and compare on DONE.
module tb_bcd_accum_n;

  logic        clk = 1'b0;
  logic        clr, vld, sub, fclr;
  logic [7:0]  din;
  logic        rdy0, done0, ovf0, err0;
  logic        rdy1, done1, ovf1, err1;
  logic [15:0] q0, q1;
  logic        vld2, sub2, fclr2;
  logic [11:0] din2;
  logic        rdy2, done2, ovf2, err2;
  logic [23:0] q2;

  always #5 clk = ~clk;

  bcd_accum_n #(.ACC_DIGITS(4), .IN_DIGITS(2), .SATURATE(0)) dut0 (
    .CLK(clk), .CLR(clr), .IN_VALID(vld), .IN_READY(rdy0), .IN_DATA(din),
    .SUB(sub), .FLAG_CLR(fclr), .Q(q0), .DONE(done0), .OVF(ovf0), .ERR(err0));

  bcd_accum_n #(.ACC_DIGITS(4), .IN_DIGITS(2), .SATURATE(1)) dut1 (
    .CLK(clk), .CLR(clr), .IN_VALID(vld), .IN_READY(rdy1), .IN_DATA(din),
    .SUB(sub), .FLAG_CLR(fclr), .Q(q1), .DONE(done1), .OVF(ovf1), .ERR(err1));

  bcd_accum_n #(.ACC_DIGITS(6), .IN_DIGITS(3), .SATURATE(0)) dut2 (
    .CLK(clk), .CLR(clr), .IN_VALID(vld2), .IN_READY(rdy2), .IN_DATA(din2),
    .SUB(sub2), .FLAG_CLR(fclr2), .Q(q2), .DONE(done2), .OVF(ovf2), .ERR(err2));

  typedef struct {
    int q;
    bit ovf;
    bit err;
  } mst_t;

  mst_t m0, m1, m2;
  mst_t exp0[$];
  mst_t exp1[$];
  mst_t exp2[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // fc: 0 none, 1 FLAG_CLR at the accept edge, 2 FLAG_CLR at the completion edge
  function automatic mst_t model_op(input mst_t s, input int nd, input bit sat,
                                    input logic [11:0] data, input int nin,
                                    input bit sb, input int fc);
    mst_t       r = s;
    bit         bad = 1'b0;
    int         d = 0;
    int         t;
    int         lim = pow10(nd);
    logic [3:0] nib;
    for (int i = nin - 1; i >= 0; i--) begin
      nib = data[i*4 +: 4];
      if (nib > 4'd9) bad = 1'b1;
      d = d * 10 + int'(nib);
    end
    if (fc == 1) begin r.ovf = 1'b0; r.err = 1'b0; end
    if (bad) begin
      r.err = 1'b1;
      return r;
    end
    if (fc == 2) begin r.ovf = 1'b0; r.err = 1'b0; end
    t = sb ? (s.q - d) : (s.q + d);
    if (t >= lim) begin
      r.ovf = 1'b1;
      r.q   = sat ? lim - 1 : t - lim;
    end else if (t < 0) begin
      r.ovf = 1'b1;
      r.q   = sat ? 0 : t + lim;
    end else begin
      r.q = t;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  mst_t        e0, e1, e2;
  logic [23:0] b0, b1, b2;

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected DONE: Q=%h", q0);
      end else begin
        e0 = exp0.pop_front();
        b0 = to_bcd(e0.q);
        chk("dut0 Q", {16'd0, q0}, {16'd0, b0[15:0]});
        chk("dut0 OVF", {31'd0, ovf0}, {31'd0, e0.ovf});
        chk("dut0 ERR", {31'd0, err0}, {31'd0, e0.err});
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected DONE: Q=%h", q1);
      end else begin
        e1 = exp1.pop_front();
        b1 = to_bcd(e1.q);
        chk("dut1 Q", {16'd0, q1}, {16'd0, b1[15:0]});
        chk("dut1 OVF", {31'd0, ovf1}, {31'd0, e1.ovf});
        chk("dut1 ERR", {31'd0, err1}, {31'd0, e1.err});
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (exp2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2 unexpected DONE: Q=%h", q2);
      end else begin
        e2 = exp2.pop_front();
        b2 = to_bcd(e2.q);
        chk("dut2 Q", {8'd0, q2}, {8'd0, b2});
        chk("dut2 OVF", {31'd0, ovf2}, {31'd0, e2.ovf});
      end
    end
  end

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    exp0.delete(); exp1.delete(); exp2.delete();
    m0 = '{q: 0, ovf: 1'b0, err: 1'b0};
    m1 = m0;
    m2 = m0;
    @(negedge clk);
  endtask

  // Issue one operand to dut0/dut1 and track IN_READY/DONE timing until it completes.
  task automatic issue(input logic [7:0] data, input bit sb, input int fc);
    int w = 0;
    int lowcnt = 0;
    bit bad;
    bit got = 1'b0;
    while (rdy0 !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (rdy0 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready wait: IN_READY=%b required 1", rdy0);
      return;
    end
    bad  = (data[3:0] > 4'd9) || (data[7:4] > 4'd9);
    vld  = 1'b1;
    din  = data;
    sub  = sb;
    fclr = (fc == 1);
    m0 = model_op(m0, 4, 1'b0, {4'd0, data}, 2, sb, fc);
    m1 = model_op(m1, 4, 1'b1, {4'd0, data}, 2, sb, fc);
    exp0.push_back(m0);
    exp1.push_back(m1);
    @(posedge clk);
    #1;
    vld  = 1'b0;
    fclr = 1'b0;
    sub  = ~sb;
    din  = 8'($urandom);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fclr = (fc == 2) && (c == 4);
      if (c == 0 && bad) chk("ERR after invalid accept", {31'd0, err0}, 32'd1);
      if (rdy0 === 1'b1) begin
        chk("IN_READY low cycles", lowcnt, bad ? 32'd1 : 32'd5);
        chk("DONE with IN_READY return", {31'd0, done0}, 32'd1);
        got = 1'b1;
        break;
      end
      lowcnt++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL completion timeout: IN_READY=%b required 1", rdy0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [11:0] d2;
    bit          rb;
    int          w;
    clr = 1'b1; vld = 1'b0; sub = 1'b0; fclr = 1'b0; din = 8'd0;
    vld2 = 1'b0; sub2 = 1'b0; fclr2 = 1'b0; din2 = 12'd0;
    m0 = '{q: 0, ovf: 1'b0, err: 1'b0};
    m1 = m0;
    m2 = m0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("reset Q", {16'd0, q0}, 32'd0);
    chk("reset IN_READY", {31'd0, rdy0}, 32'd1);
    chk("reset DONE", {31'd0, done0}, 32'd0);
    chk("reset OVF/ERR", {30'd0, ovf0, err0}, 32'd0);
    chk("reset dut2 Q", {8'd0, q2}, 32'd0);

    repeat (4) issue(8'h47, 1'b0, 0);
    chk("four adds of 47", {16'd0, q0}, 32'h0188);

    do_clear();
    repeat (101) issue(8'h99, 1'b0, 0);
    issue(8'h09, 1'b1, 0);
    chk("preset 9990", {16'd0, q0}, 32'h9990);
    issue(8'h15, 1'b0, 2);
    chk("wrap add Q", {16'd0, q0}, 32'h0005);
    chk("sat add Q", {16'd0, q1}, 32'h9999);
    chk("OVF survives FLAG_CLR", {30'd0, ovf0, ovf1}, 32'd3);

    do_clear();
    issue(8'h10, 1'b0, 0);
    issue(8'h25, 1'b1, 0);
    chk("wrap sub Q", {16'd0, q0}, 32'h9985);
    chk("sat sub Q", {16'd0, q1}, 32'h0000);

    issue(8'h3A, 1'b0, 0);
    chk("invalid keeps Q", {16'd0, q0}, 32'h9985);
    chk("invalid flags", {30'd0, ovf0, err0}, 32'd3);
    issue(8'h01, 1'b0, 1);
    chk("FLAG_CLR at accept", {30'd0, ovf0, err0}, 32'd0);

    // CLR on the second RUN edge with IN_VALID held throughout
    vld = 1'b1; din = 8'h12; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    din = 8'h34;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    exp0.delete(); exp1.delete();
    m0 = '{q: 0, ovf: 1'b0, err: 1'b0};
    m1 = m0;
    @(negedge clk);
    chk("abort Q", {16'd0, q0}, 32'd0);
    chk("abort DONE", {31'd0, done0}, 32'd0);
    chk("abort IN_READY", {31'd0, rdy0}, 32'd1);
    m0 = model_op(m0, 4, 1'b0, {4'd0, din}, 2, 1'b0, 0);
    m1 = model_op(m1, 4, 1'b1, {4'd0, din}, 2, 1'b0, 0);
    exp0.push_back(m0);
    exp1.push_back(m1);
    @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    chk("held IN_VALID accepted", {31'd0, rdy0}, 32'd0);
    issue(8'h00, 1'b0, 0);
    chk("after abort Q", {16'd0, q0}, 32'h0034);

    for (int n = 0; n < 120; n++) begin
      rd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 15) == 0) rd[3:0] = 4'($urandom_range(10, 15));
      rb = 1'($urandom_range(0, 1));
      if (rd[3:0] > 4'd9) issue(rd, rb, int'($urandom_range(0, 1)));
      else issue(rd, rb, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    vld2 = 1'b1;
    for (int n = 0; n < 1002; n++) begin
      d2 = (n < 1001) ? 12'h999 : 12'h001;
      w = 0;
      while (rdy2 !== 1'b1 && w < 30) begin
        @(negedge clk);
        w++;
      end
      if (rdy2 !== 1'b1) begin
        checks++; errors++;
        $display("FAIL dut2 ready wait: IN_READY=%b required 1", rdy2);
        break;
      end
      din2 = d2;
      m2 = model_op(m2, 6, 1'b0, d2, 3, 1'b0, 0);
      exp2.push_back(m2);
      @(posedge clk);
      @(negedge clk);
    end
    vld2 = 1'b0;

    w = 0;
    while ((exp0.size() + exp1.size() + exp2.size()) != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard drained", exp0.size() + exp1.size() + exp2.size(), 32'd0);
    chk("dut2 final Q", {8'd0, q2}, 32'd0);
    chk("dut2 final OVF", {31'd0, ovf2}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
